// File: rtl/rxpfc_pkg.sv
// rxpfc_pause shared constants, parser states and field helpers.
// Optional statistics are enabled with RXPFC_STATS_EN.
package rxpfc_pkg;

   localparam logic [47:0] CTRL_DA  = 48'h0180_C200_0001;
   localparam logic [15:0] CTRL_ET  = 16'h8808;
   localparam logic [15:0] OP_PAUSE = 16'h0001;
   localparam logic [15:0] OP_PFC   = 16'h0101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_P0,
      S_P1,
      S_P2,
      S_EOP,
      S_SKIP
   } state_t;

   // Big-endian 16-bit field from byte pair (2k, 2k+1) of a beat
   function automatic logic [15:0] pair(input logic [63:0] d,
                                        input int unsigned k);
      logic [63:0] s;
      s = d >> (16 * k);
      return {s[7:0], s[15:8]};
   endfunction

   function automatic logic [47:0] da_of(input logic [63:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40]};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/rxpfc_timer.sv
// One per-class pause timer: clear beats load, load beats tick decrement.
module rxpfc_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         active
);

   logic [W-1:0] nxt;

   always_comb begin
      nxt = count;
      if (clr)
         nxt = '0;
      else if (load)
         nxt = load_val;
      else if (tick && count != '0)
         nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         active <= 1'b0;
      end else begin
         count  <= nxt;
         active <= |nxt;
      end
   end

endmodule

// File: rtl/rxpfc_pause.sv
// RX PAUSE / PFC parser with per-class pause timers.
// Define RXPFC_STATS_EN for saturating frame statistics outputs.
module rxpfc_pause
   import rxpfc_pkg::*;
#(
   parameter int NUM_CLASSES = 8,
   parameter int QUANTA_W    = 16,
   parameter int SUBQ_W      = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [63:0]            tdata_i,
   input  logic [7:0]             tkeep_i,
   input  logic                   tvalid_i,
   input  logic                   tlast_i,
   input  logic                   tuser_i,
   output logic                   tuser_o,
   input  logic                   cfg_rx_pause_enable,
   input  logic                   cfg_pfc_enable,
   input  logic                   cfg_drop_ctrl,
   input  logic [SUBQ_W-1:0]      cfg_sub_quanta_count,
   output logic [NUM_CLASSES-1:0] rx_pause_active
`ifdef RXPFC_STATS_EN
   ,
   output logic [31:0]            stat_pause_frames,
   output logic [31:0]            stat_pfc_frames,
   output logic [31:0]            stat_bad_ctrl
`endif
);

   state_t             state, nxt;
   logic [15:0]        opcode, quanta;
   logic [7:0]         cev;
   logic [15:0]        tm [8];
   logic [SUBQ_W-1:0]  pre, n_m1;
   logic [QUANTA_W-1:0] cnt [NUM_CLASSES];
   logic               eop, consume, any_nz, running, tick;
   logic               unused_ok;

   assign unused_ok = ^tkeep_i;

   assign eop     = (state == S_EOP) && tvalid_i && tlast_i;
   assign consume = eop && tuser_i;
   assign tuser_o = tuser_i & ~(eop & cfg_drop_ctrl);

   always_comb begin
      nxt = state;
      if (tvalid_i) begin
         unique case (state)
            S_IDLE:
               nxt = (da_of(tdata_i) == CTRL_DA) ? S_HDR : S_SKIP;
            S_HDR:
               nxt = (pair(tdata_i, 2) == CTRL_ET) ? S_P0 : S_SKIP;
            S_P0:
               if (opcode == OP_PAUSE && cfg_rx_pause_enable)
                  nxt = S_EOP;
               else if (opcode == OP_PFC && cfg_pfc_enable)
                  nxt = S_P1;
               else
                  nxt = S_SKIP;
            S_P1:    nxt = S_P2;
            S_P2:    nxt = S_EOP;
            S_EOP:   nxt = S_EOP;
            S_SKIP:  nxt = S_SKIP;
            default: nxt = S_IDLE;
         endcase
         if (tlast_i)
            nxt = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         opcode <= '0;
         quanta <= '0;
         cev    <= '0;
         for (int i = 0; i < 8; i++)
            tm[i] <= '0;
      end else begin
         state <= nxt;
         if (tvalid_i) begin
            if (state == S_HDR)
               opcode <= pair(tdata_i, 3);
            if (state == S_P0) begin
               quanta <= pair(tdata_i, 0);
               cev    <= tdata_i[15:8];
               tm[0]  <= pair(tdata_i, 1);
               tm[1]  <= pair(tdata_i, 2);
               tm[2]  <= pair(tdata_i, 3);
            end
            if (state == S_P1) begin
               tm[3] <= pair(tdata_i, 0);
               tm[4] <= pair(tdata_i, 1);
               tm[5] <= pair(tdata_i, 2);
               tm[6] <= pair(tdata_i, 3);
            end
            if (state == S_P2)
               tm[7] <= pair(tdata_i, 0);
         end
      end
   end

   // Prescaler only runs while some class is paused
   assign n_m1 = (cfg_sub_quanta_count == '0) ? '0
               : cfg_sub_quanta_count - 1'b1;

   always_comb begin
      any_nz = 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++)
         any_nz = any_nz | (|cnt[i]);
   end

   assign running = any_nz && cfg_rx_pause_enable;
   assign tick    = running && (pre == n_m1);

   always_ff @(posedge clk) begin
      if (rst || !running || tick)
         pre <= '0;
      else
         pre <= pre + 1'b1;
   end

   for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_tmr
      logic                ld;
      logic [QUANTA_W-1:0] lv;

      assign ld = consume &&
                  (opcode == OP_PAUSE || (opcode == OP_PFC && cev[i]));
      assign lv = (opcode == OP_PFC) ? QUANTA_W'(tm[i])
                                     : QUANTA_W'(quanta);

      rxpfc_timer #(.W(QUANTA_W)) u_tmr (
         .clk      (clk),
         .rst      (rst),
         .load     (ld),
         .load_val (lv),
         .tick     (tick),
         .clr      (!cfg_rx_pause_enable),
         .count    (cnt[i]),
         .active   (rx_pause_active[i])
      );
   end

`ifdef RXPFC_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pause_frames <= '0;
         stat_pfc_frames   <= '0;
         stat_bad_ctrl     <= '0;
      end else if (eop) begin
         if (!tuser_i)
            stat_bad_ctrl <= sat_inc(stat_bad_ctrl);
         else if (opcode == OP_PAUSE)
            stat_pause_frames <= sat_inc(stat_pause_frames);
         else if (opcode == OP_PFC)
            stat_pfc_frames <= sat_inc(stat_pfc_frames);
      end
   end
`endif

endmodule
